// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the IF/ID/EX pipeline: load-use stalls, post-branch flush, memory wait and watchdog.
// Optional per-cycle stall/flush performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  stall_all,
    output logic [1:0]            ctrl_state,
    output logic                  mem_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RSVD     = 2'd3
    } state_t;

    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] WCNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TO_LIM     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_fcnt;
    logic [2:0]       w_fcnt_nxt;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_nxt;
    logic             r_mem_timeout;
    logic             w_timeout_nxt;

    logic             w_load_use;
    logic             w_run_eval;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_if_id_flush;
    logic             w_id_ex_bubble;
    logic             w_stall_all;

    assign w_load_use = ex_mem_read & id_valid & (ex_rt != '0) &
                        ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_stall_all    = 1'b0;
        w_state_nxt    = ST_RUN;
        w_fcnt_nxt     = r_fcnt;
        w_wcnt_nxt     = r_wcnt;
        w_run_eval     = 1'b0;

        case (r_state)
            ST_FLUSH: begin
                // EX only holds bubbles here, so a taken-branch indication is meaningless
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
                w_state_nxt    = ST_FLUSH;
                if (mem_busy) begin
                    w_stall_all   = 1'b1;
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                end else if (r_fcnt <= 3'd1) begin
                    w_state_nxt = ST_RUN;
                    w_fcnt_nxt  = 3'd0;
                end else begin
                    w_fcnt_nxt = r_fcnt - 3'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    w_stall_all   = 1'b1;
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_state_nxt   = ST_MEM_WAIT;
                    if (r_wcnt != WCNT_MAX) begin
                        w_wcnt_nxt = r_wcnt + CNT_ONE;
                    end
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            default: w_run_eval = 1'b1;
        endcase

        // The release cycle of a memory wait behaves exactly like RUN, so a held branch is serviced here
        if (w_run_eval) begin
            w_wcnt_nxt = '0;
            if (mem_busy) begin
                w_stall_all   = 1'b1;
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_state_nxt   = ST_MEM_WAIT;
                w_wcnt_nxt    = CNT_ONE;
            end else if (ex_branch_taken) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_state_nxt = ST_FLUSH;
                    w_fcnt_nxt  = FLUSH_INIT;
                end
            end else if (w_load_use) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
            end
        end
    end

    assign w_timeout_nxt = r_mem_timeout | ((w_wcnt_nxt != '0) && (w_wcnt_nxt >= TO_LIM));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state       <= ST_RUN;
            r_fcnt        <= 3'd0;
            r_wcnt        <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fcnt        <= w_fcnt_nxt;
            r_wcnt        <= w_wcnt_nxt;
            r_mem_timeout <= w_timeout_nxt;
        end
    end

    // Reset forces a safe pipe: nothing advances and IF/ID, ID/EX hold NOPs
    assign pc_write     = RESET ? 1'b0 : w_pc_write;
    assign if_id_write  = RESET ? 1'b0 : w_if_id_write;
    assign if_id_flush  = RESET ? 1'b1 : w_if_id_flush;
    assign id_ex_bubble = RESET ? 1'b1 : w_id_ex_bubble;
    assign stall_all    = RESET ? 1'b0 : w_stall_all;
    assign ctrl_state   = r_state;
    assign mem_timeout  = r_mem_timeout;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_cycles;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != WCNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_if_id_flush && (r_flush_cycles != WCNT_MAX)) begin
                r_flush_cycles <= r_flush_cycles + CNT_ONE;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, TIMEOUT=8); perf counters checked when HAZ_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rt = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rt = '0;
    logic       ex_branch_taken = 1'b0;
    logic       mem_busy = 1'b0;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       stall_all;
    logic [1:0] ctrl_state;
    logic       mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_cycles;
`endif

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .FLUSH_CYCLES(3),
        .TIMEOUT     (8),
        .CNT_W       (16)
    ) dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .stall_all      (stall_all),
        .ctrl_state     (ctrl_state),
        .mem_timeout    (mem_timeout)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_cycles   (flush_cycles)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic       pc;
        logic       ifw;
        logic       fl;
        logic       bub;
        logic       stall;
        logic [1:0] st;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_step = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic pc, ifw, fl, bub, stall, input logic [1:0] st, input logic to);
        exp_t e;
        e.pc = pc; e.ifw = ifw; e.fl = fl; e.bub = bub; e.stall = stall; e.st = st; e.to = to;
        return e;
    endfunction

    // Drive one cycle of stimulus just after the edge and queue the expected outputs for that cycle
    task automatic drive(input logic rst, busy, br, mr, idv, urt,
                         input logic [4:0] rs, rt, exrt, input exp_t e);
        @(posedge CLOCK);
        #1;
        RESET = rst; mem_busy = busy; ex_branch_taken = br; ex_mem_read = mr;
        id_valid = idv; id_uses_rt = urt; id_rs = rs; id_rt = rt; ex_rt = exrt;
        sb_q.push_back(e);
    endtask

    task automatic idle(input exp_t e);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, e);
    endtask

    always @(negedge CLOCK) begin : mon
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("s%0d.pc_write", n_step), {31'd0, pc_write}, {31'd0, e.pc});
            check($sformatf("s%0d.if_id_write", n_step), {31'd0, if_id_write}, {31'd0, e.ifw});
            check($sformatf("s%0d.if_id_flush", n_step), {31'd0, if_id_flush}, {31'd0, e.fl});
            check($sformatf("s%0d.id_ex_bubble", n_step), {31'd0, id_ex_bubble}, {31'd0, e.bub});
            check($sformatf("s%0d.stall_all", n_step), {31'd0, stall_all}, {31'd0, e.stall});
            check($sformatf("s%0d.ctrl_state", n_step), {30'd0, ctrl_state}, {30'd0, e.st});
            check($sformatf("s%0d.mem_timeout", n_step), {31'd0, mem_timeout}, {31'd0, e.to});
            n_step++;
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        exp_t RST, IDL, LU, BR0, FL1;
        RST = mk(0, 0, 1, 1, 0, 2'd0, 0);
        IDL = mk(1, 1, 0, 0, 0, 2'd0, 0);
        LU  = mk(0, 0, 0, 1, 0, 2'd0, 0);
        BR0 = mk(1, 1, 1, 1, 0, 2'd0, 0);
        FL1 = mk(1, 1, 1, 1, 0, 2'd1, 0);

        @(posedge CLOCK);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RST);
        idle(IDL);
        idle(IDL);

        // load-use on rs, zero register, rt with and without use, no valid, no load
        drive(0, 0, 0, 1, 1, 0, 5'd5, 5'd0, 5'd5, LU);
        drive(0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, IDL);
        drive(0, 0, 0, 1, 1, 1, 5'd3, 5'd7, 5'd7, LU);
        drive(0, 0, 0, 1, 1, 0, 5'd3, 5'd7, 5'd7, IDL);
        drive(0, 0, 0, 1, 0, 0, 5'd5, 5'd0, 5'd5, IDL);
        drive(0, 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd5, IDL);

        // single branch: three flush cycles, states 0,1,1 then 0
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, BR0);
        idle(FL1);
        idle(FL1);
        idle(IDL);

        // branch held: ignored during FLUSH, taken again once back in RUN
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, BR0);
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, FL1);
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, FL1);
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, BR0);
        idle(FL1);
        idle(FL1);
        idle(IDL);

        // branch outranks a simultaneous load-use
        drive(0, 0, 1, 1, 1, 0, 5'd5, 5'd0, 5'd5, BR0);
        idle(FL1);
        idle(FL1);
        idle(IDL);

        // mem_busy inside FLUSH freezes the flush count
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, BR0);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 1, 1, 1, 2'd1, 0));
        idle(FL1);
        idle(FL1);
        idle(IDL);

        // memory wait with branch held: flush only in the release cycle
        drive(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 1, 2'd0, 0));
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 1, 2'd2, 0));
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(1, 1, 1, 1, 0, 2'd2, 0));
        idle(FL1);
        idle(FL1);
        idle(IDL);

        // load-use seen in the release cycle of a memory wait
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 1, 2'd0, 0));
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 1, 2'd2, 0));
        drive(0, 0, 0, 1, 1, 0, 5'd5, 5'd0, 5'd5, mk(0, 0, 0, 1, 0, 2'd2, 0));
        idle(IDL);

        // reset in the middle of a flush discards it
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, BR0);
        idle(FL1);
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 1, 1, 0, 2'd1, 0));
        idle(IDL);
        idle(IDL);

        // watchdog: 10 busy cycles, error from the cycle the wait count reaches 8
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 1, 2'd0, 0));
        for (int i = 1; i < 10; i++)
            drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 1, 2'd2, (i >= 8) ? 1'b1 : 1'b0));
        idle(mk(1, 1, 0, 0, 0, 2'd2, 1));
        idle(mk(1, 1, 0, 0, 0, 2'd0, 1));
        idle(mk(1, 1, 0, 0, 0, 2'd0, 1));
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, mk(0, 0, 1, 1, 0, 2'd0, 1));
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RST);
        idle(IDL);

`ifdef HAZ_PERF_CNT_EN
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RST);
        idle(IDL);
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, BR0);
        idle(FL1);
        idle(FL1);
        idle(IDL);
        @(negedge CLOCK);
        #1;
        check("perf.flush_cycles", {16'd0, flush_cycles}, 32'd3);
        check("perf.stall_cycles", {16'd0, stall_cycles}, 32'd0);
`else
        @(negedge CLOCK);
        #1;
`endif
        check("sb_drain", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
